// File: rtl/sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : sum_accumulator
//  Purpose  : Sums BLOCK_LEN beats of a 9-bit adder result {carry, sum[7:0]}
//             into an ACC_W-bit total. Overflow is reported and is sticky
//             within a block. Handshakes are valid/ready on both sides.
//  Options  : SUM_ACC_SAT_EN - when defined, the accumulator saturates at
//             all-ones on overflow. When undefined, it wraps modulo 2^ACC_W.
//  Revision : 1.0 - initial release
// ============================================================================
module sum_accumulator #(
   parameter int ACC_W     = 16,
   parameter int BLOCK_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_sum,
   input  logic             in_carry,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy
);

   localparam int               CNT_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t           state, state_next;
   logic [ACC_W-1:0] acc, acc_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             ovf, ovf_next;

   logic [ACC_W-1:0] operand;
   logic [ACC_W:0]   sum_ext;
   logic             carry_out;
   logic [ACC_W-1:0] acc_add;

   // Beat operand: the 9-bit adder result, zero-extended (ACC_W >= 9).
   assign operand   = ACC_W'({in_carry, in_sum});
   assign sum_ext   = {1'b0, acc} + {1'b0, operand};
   assign carry_out = sum_ext[ACC_W];

`ifdef SUM_ACC_SAT_EN
   assign acc_add = carry_out ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
   assign acc_add = sum_ext[ACC_W-1:0];
`endif

   // Next-state and handshake logic. Clear overrides any beat or handshake.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      cnt_next   = cnt;
      ovf_next   = ovf;
      in_ready   = (state == ACCUM);
      out_valid  = (state == DONE);

      if (clear) begin
         state_next = ACCUM;
         acc_next   = '0;
         cnt_next   = '0;
         ovf_next   = 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  acc_next = acc_add;
                  ovf_next = ovf | carry_out;
                  if (cnt == LAST_CNT) begin
                     // The count returns to zero here; DONE alone keeps busy high.
                     cnt_next   = '0;
                     state_next = DONE;
                  end else begin
                     cnt_next = cnt + CNT_W'(1);
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_next = ACCUM;
                  acc_next   = '0;
                  cnt_next   = '0;
                  ovf_next   = 1'b0;
               end
            end
            default: state_next = ACCUM;
         endcase
      end
   end

   // State register; reset drops any partial block or pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_next;
   end

   // Datapath registers: accumulator, beat counter and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         acc <= acc_next;
         cnt <= cnt_next;
         ovf <= ovf_next;
      end
   end

   assign out_acc = acc;
   assign out_ovf = ovf;
   assign busy    = (cnt != '0) || (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_sum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sum_accumulator
//  Purpose  : Self-checking bench for sum_accumulator. It covers the default
//             16-bit configuration and a 10-bit instance for overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_carry, clear, out_ready;
   logic [7:0]  in_sum;
   logic        in_ready, out_valid, out_ovf, busy;
   logic [15:0] out_acc;

   logic        in_valid10, in_carry10, clear10, out_ready10;
   logic [7:0]  in_sum10;
   logic        in_ready10, out_valid10, out_ovf10, busy10;
   logic [9:0]  out_acc10;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] acc;
      logic        ovf;
   } exp_t;
   exp_t sb[$];

   typedef struct packed {
      logic [3:0][7:0] s;
      logic [3:0]      c;
      logic [15:0]     acc;
      logic            ovf;
   } vec_t;

   always #5 clk = ~clk;

   sum_accumulator #(.ACC_W(16), .BLOCK_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sum(in_sum), .in_carry(in_carry), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_ovf(out_ovf), .busy(busy)
   );

   sum_accumulator #(.ACC_W(10), .BLOCK_LEN(4)) dut10 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid10), .in_ready(in_ready10),
      .in_sum(in_sum10), .in_carry(in_carry10), .clear(clear10),
      .out_valid(out_valid10), .out_ready(out_ready10), .out_acc(out_acc10),
      .out_ovf(out_ovf10), .busy(busy10)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat and wait (bounded) until it is accepted.
   task automatic send_beat(input logic [7:0] s, input logic c);
      bit ok = 0;
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL beat_accept_timeout: got in_ready=0 expected 1");
      end
      step();
      in_valid = 1'b0;
   endtask

   // Scoreboard: compare each result when the output handshake occurs.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got acc=0x%0h expected no result", out_acc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_out_acc", 32'(out_acc), 32'(e.acc));
            chk("sb_out_ovf", 32'(out_ovf), 32'(e.ovf));
         end
      end
   end

   initial begin
      vec_t vecs[4];
      vecs[0] = '{s: {8'h40, 8'h30, 8'h20, 8'h10}, c: 4'b0000, acc: 16'h00A0, ovf: 1'b0};
      vecs[1] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, c: 4'b1111, acc: 16'h07FC, ovf: 1'b0};
      vecs[2] = '{s: {8'h00, 8'hFF, 8'h80, 8'h01}, c: 4'b1001, acc: 16'h0380, ovf: 1'b0};
      vecs[3] = '{s: {8'h00, 8'h00, 8'h00, 8'h00}, c: 4'b0000, acc: 16'h0000, ovf: 1'b0};

      rst_n = 1'b0; in_valid = 0; in_sum = 0; in_carry = 0; clear = 0; out_ready = 1;
      in_valid10 = 0; in_sum10 = 0; in_carry10 = 0; clear10 = 0; out_ready10 = 1;

      // Reset state
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_acc",   32'(out_acc),   0);
      chk("rst_in_ready",  32'(in_ready),  1);
      chk("rst_busy",      32'(busy),      0);
      step();
      rst_n = 1'b1;
      step();

      // Table-driven blocks with a latency and pulse-width check each
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{acc: vecs[i].acc, ovf: vecs[i].ovf});
         for (int b = 0; b < 4; b++) begin
            send_beat(vecs[i].s[b], vecs[i].c[b]);
            if (b == 1) chk("busy_mid_block", 32'(busy), 1);
         end
         @(negedge clk);
         chk("valid_latency1", 32'(out_valid), 1);
         chk("valid_acc",      32'(out_acc),   32'(vecs[i].acc));
         step();
         @(negedge clk);
         chk("valid_one_cycle", 32'(out_valid), 0);
         chk("idle_busy",       32'(busy),      0);
         step();
      end

      // Backpressure: result held, upstream stalled, no beat counted
      out_ready = 1'b0;
      sb.push_back('{acc: 16'h00AA, ovf: 1'b0});
      send_beat(8'h11, 1'b0);
      send_beat(8'h22, 1'b0);
      send_beat(8'h33, 1'b0);
      send_beat(8'h44, 1'b0);
      in_valid = 1'b1;
      in_sum   = 8'h55;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_in_ready",  32'(in_ready),  0);
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_out_acc",   32'(out_acc),   32'h00AA);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("bp_after_acc",  32'(out_acc), 0);
      chk("bp_after_busy", 32'(busy),    0);
      step();
      sb.push_back('{acc: 16'h0004, ovf: 1'b0});
      for (int b = 0; b < 4; b++) send_beat(8'h01, 1'b0);
      @(negedge clk);
      chk("bp_next_block", 32'(out_acc), 32'h0004);
      step();
      step();

      // Clear with a simultaneous beat: that beat is dropped
      send_beat(8'h05, 1'b0);
      send_beat(8'h05, 1'b0);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_sum   = 8'h77;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("clr_acc",  32'(out_acc), 0);
      chk("clr_busy", 32'(busy),    0);
      step();
      sb.push_back('{acc: 16'h0004, ovf: 1'b0});
      for (int b = 0; b < 4; b++) send_beat(8'h01, 1'b0);
      @(negedge clk);
      chk("clr_next_block", 32'(out_acc), 32'h0004);
      step();
      step();

      // Asynchronous reset mid-block, checked before any clock edge
      send_beat(8'h12, 1'b0);
      send_beat(8'h34, 1'b0);
      chk("pre_rst_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_acc",   32'(out_acc),   0);
      chk("arst_in_ready",  32'(in_ready),  1);
      chk("arst_busy",      32'(busy),      0);
      step();
      rst_n = 1'b1;
      step();

      // Overflow on the 10-bit instance
      in_valid10 = 1'b1;
      in_sum10   = 8'hFF;
      in_carry10 = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("ovf_in_ready", 32'(in_ready10), 1);
         step();
      end
      in_valid10 = 1'b0;
      @(negedge clk);
      chk("ovf_valid", 32'(out_valid10), 1);
`ifdef SUM_ACC_SAT_EN
      chk("ovf_acc", 32'(out_acc10), 32'h3FF);
`else
      chk("ovf_acc", 32'(out_acc10), 32'h3FC);
`endif
      chk("ovf_flag", 32'(out_ovf10), 1);
      step();
      @(negedge clk);
      chk("ovf_cleared", 32'(out_ovf10), 0);

      chk("sb_drained", 32'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire
